shift_sequencer: RTL and testbench

Sequencing and arbitration controller for the combinational barrel shifter (SLL/SLR/SRL/SRA, 4-bit amount). It accepts shift requests from two requesters with round-robin arbitration and extends the shift amount to 5 bits (0–31) by issuing one or more shifter passes of at most 15. It then returns the registered result and SZCV flags through a valid/ready response channel. It sits between the CPU execute stage and the shifter instance and is the only driver of the shifter's inputs.

---
 rtl/shift_sequencer_if.sv | 41 ++++
 rtl/shift_sequencer.sv | 109 ++++++++++
 tb/tb_shift_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Signal bundle around shift_sequencer: two request ports, the shifter drive/return
// and the response channel. slave is the sequencer's view, master the environment's.
interface shift_sequencer_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_br;
  logic [4:0]  req0_amt;
  logic [3:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_br;
  logic [4:0]  req1_amt;
  logic [3:0]  req1_op;
  logic [15:0] sh_br;
  logic [3:0]  sh_d;
  logic [3:0]  sh_op;
  logic [15:0] sh_out;
  logic [3:0]  sh_szcv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_out;
  logic [3:0]  rsp_szcv;
  logic        busy;

  modport slave (
    input  req0_valid, req0_br, req0_amt, req0_op,
           req1_valid, req1_br, req1_amt, req1_op,
           sh_out, sh_szcv, rsp_ready,
    output req0_ready, req1_ready, sh_br, sh_d, sh_op,
           rsp_valid, rsp_id, rsp_out, rsp_szcv, busy
  );

  modport master (
    output req0_valid, req0_br, req0_amt, req0_op,
           req1_valid, req1_br, req1_amt, req1_op,
           sh_out, sh_szcv, rsp_ready,
    input  req0_ready, req1_ready, sh_br, sh_d, sh_op,
           rsp_valid, rsp_id, rsp_out, rsp_szcv, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin front end for the 4-bit barrel shifter: splits 0-31 shift amounts into
// passes of at most 15 and returns the result and flags on a valid/ready channel.
//
// state | meaning
// IDLE  | waiting for a request, grant by round robin
// PASS  | one shifter pass per cycle until remaining amount is spent
// RESP  | result held on rsp_* until rsp_ready
module shift_sequencer (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PASS, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  flags_q, flags_d;
  logic        id_q, id_d;
  logic        rr_q, rr_d;
  logic        gnt1;
  logic [3:0]  pass_d;
  logic        is_shift;

  assign gnt1     = bus.req1_valid & (~bus.req0_valid | rr_q);
  assign pass_d   = (rem_q > 5'd15) ? 4'd15 : rem_q[3:0];
  assign is_shift = (op_q[3:2] == 2'b10);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    rem_d          = rem_q;
    op_d           = op_q;
    flags_d        = flags_q;
    id_d           = id_q;
    rr_d           = rr_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.sh_br      = 16'h0000;
    bus.sh_d       = 4'h0;
    bus.sh_op      = 4'h0;
    bus.rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = rst_n & bus.req0_valid & ~gnt1;
        bus.req1_ready = rst_n & bus.req1_valid & gnt1;
        if (bus.req0_valid | bus.req1_valid) begin
          state_d = PASS;
          if (gnt1) begin
            acc_d = bus.req1_br;
            rem_d = bus.req1_amt;
            op_d  = bus.req1_op;
            id_d  = 1'b1;
            rr_d  = 1'b0;
          end else begin
            acc_d = bus.req0_br;
            rem_d = bus.req0_amt;
            op_d  = bus.req0_op;
            id_d  = 1'b0;
            rr_d  = 1'b1;
          end
        end
      end
      PASS: begin
        bus.sh_br = acc_q;
        bus.sh_op = op_q;
        bus.sh_d  = pass_d;
        acc_d     = bus.sh_out;
        // V is never reported, whatever the shifter drives
        flags_d   = bus.sh_szcv & 4'b1110;
        rem_d     = rem_q - {1'b0, pass_d};
        if ((rem_d == 5'd0) || !is_shift) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_out  = acc_q;
  assign bus.rsp_szcv = flags_q;
  assign bus.rsp_id   = id_q;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      rem_q   <= 5'd0;
      op_q    <= 4'h0;
      flags_q <= 4'h0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural barrel shifter, scoreboard of expected
// responses queued at each request handshake and checked when the response appears.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  shift_sequencer_if sif();

  shift_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  // behavioural shifter driven by the sequencer
  logic [31:0] m_t;
  logic [15:0] m_o;
  logic        m_c;
  always_comb begin
    m_t = 32'h0;
    m_o = 16'h0;
    m_c = 1'b0;
    case (sif.sh_op)
      4'b1000: begin m_t = {16'h0, sif.sh_br} << sif.sh_d; m_o = m_t[15:0]; m_c = m_t[16]; end
      4'b1001: begin m_t = {sif.sh_br, sif.sh_br} << sif.sh_d; m_o = m_t[31:16];
                     m_c = (sif.sh_d != 4'd0) & m_o[0]; end
      4'b1010: begin m_t = {sif.sh_br, 16'h0} >> sif.sh_d; m_o = m_t[31:16]; m_c = m_t[15]; end
      4'b1011: begin m_t = $signed({sif.sh_br, 16'h0}) >>> sif.sh_d; m_o = m_t[31:16]; m_c = m_t[15]; end
      default: ;
    endcase
    sif.sh_out  = m_o;
    sif.sh_szcv = {m_o[15], (m_o == 16'h0), m_c, 1'b0};
  end

  typedef struct {
    logic        id;
    logic [15:0] out;
    logic [3:0]  szcv;
    int          p;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // whole-amount reference: one shift by 0..31, C = last bit shifted out overall
  function automatic logic [19:0] ref_result(logic [3:0] op, logic [15:0] br, logic [4:0] amt);
    logic [47:0] v;
    logic [31:0] t;
    logic [15:0] o;
    logic        c;
    o = 16'h0; c = 1'b0; v = 48'h0; t = 32'h0;
    case (op)
      4'b1000: begin v = {32'h0, br} << amt; o = v[15:0]; c = v[16]; end
      4'b1001: begin t = {br, br} << amt[3:0]; o = t[31:16]; c = (amt != 5'd0) & o[0]; end
      4'b1010: begin v = {br, 32'h0} >> amt; o = v[47:32]; c = v[31]; end
      4'b1011: begin v = $signed({br, 32'h0}) >>> amt; o = v[47:32]; c = v[31]; end
      default: ;
    endcase
    return {o, o[15], (o == 16'h0), c, 1'b0};
  endfunction

  function automatic int exp_passes(logic [3:0] op, logic [4:0] amt);
    if (op[3:2] != 2'b10 || amt == 5'd0) return 1;
    return (int'(amt) + 14) / 15;
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [3:0] op,
                           input logic [15:0] br, input logic [4:0] amt);
    if (id == 1'b0) begin
      sif.req0_valid = v; sif.req0_op = op; sif.req0_br = br; sif.req0_amt = amt;
    end else begin
      sif.req1_valid = v; sif.req1_op = op; sif.req1_br = br; sif.req1_amt = amt;
    end
  endtask

  // called at a negedge; returns at the negedge of the first PASS cycle
  task automatic send(input logic id, input logic [3:0] op, input logic [15:0] br,
                      input logic [4:0] amt, input exp_t e, output bit ok);
    ok = 1'b0;
    drive_req(id, 1'b1, op, br, amt);
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((id == 1'b0 && sif.req0_ready) || (id == 1'b1 && sif.req1_ready)) begin
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    drive_req(id, 1'b0, op, br, amt);
  endtask

  // starts at the negedge of cycle 1; with rsp_ready high, returns at the IDLE negedge
  task automatic wait_rsp(output int lat, output int npass, output int dsum, output logic id,
                          output logic [15:0] out, output logic [3:0] szcv, output bit to);
    lat = 1; npass = 0; dsum = 0; to = 1'b1; id = 1'b0; out = 16'h0; szcv = 4'h0;
    for (int i = 0; i < 40; i++) begin
      if (sif.rsp_valid) begin
        to = 1'b0; id = sif.rsp_id; out = sif.rsp_out; szcv = sif.rsp_szcv;
        break;
      end
      if (sif.sh_op != 4'h0) begin
        npass++;
        dsum += int'(sif.sh_d);
      end
      @(negedge clk);
      lat++;
    end
    if (!to && sif.rsp_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sif.req0_valid = 1'b1;
    sif.req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (sif.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b want=0", sif.req0_ready); end
    total++; if (sif.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%b want=0", sif.req1_ready); end
    total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", sif.busy); end
    total++; if (sif.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", sif.rsp_valid); end
    total++; if (sif.rsp_out !== 16'h0) begin bad++; $display("FAIL reset_rsp_out got=%h want=0000", sif.rsp_out); end
    total++; if (sif.rsp_szcv !== 4'h0) begin bad++; $display("FAIL reset_rsp_szcv got=%b want=0000", sif.rsp_szcv); end
    total++; if (sif.rsp_id !== 1'b0) begin bad++; $display("FAIL reset_rsp_id got=%b want=0", sif.rsp_id); end
    total++; if ({sif.sh_br, sif.sh_d, sif.sh_op} !== 24'h0) begin bad++;
      $display("FAIL reset_sh_idle got=%h/%h/%h want=0/0/0", sif.sh_br, sif.sh_d, sif.sh_op); end
    sif.req0_valid = 1'b0;
    sif.req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // both requesters valid straight out of reset: 0,1,0,1 with P+2 spacing
  task automatic test_back_to_back();
    exp_t e;
    int   nrsp;
    int   last_cyc;
    int   gap_exp[3];
    gap_exp[0] = 4; gap_exp[1] = 3; gap_exp[2] = 4;
    nrsp = 0; last_cyc = 0;
    sif.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 4'b1000, 16'h8001, 5'd1);
    drive_req(1'b1, 1'b1, 4'b1011, 16'h8000, 5'd20);
    for (int cyc = 0; cyc < 80 && nrsp < 4; cyc++) begin
      #1;
      if (sif.rsp_valid) begin
        total++; if (sif.rsp_id !== nrsp[0]) begin bad++;
          $display("FAIL b2b_order[%0d] got=%b want=%b", nrsp, sif.rsp_id, nrsp[0]); end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++; if ({sif.rsp_out, sif.rsp_szcv} !== {e.out, e.szcv}) begin bad++;
            $display("FAIL b2b_data[%0d] got=%h/%b want=%h/%b", nrsp, sif.rsp_out, sif.rsp_szcv, e.out, e.szcv); end
        end
        if (nrsp > 0) begin
          total++; if (cyc - last_cyc != gap_exp[nrsp-1]) begin bad++;
            $display("FAIL b2b_gap[%0d] got=%0d want=%0d", nrsp, cyc - last_cyc, gap_exp[nrsp-1]); end
        end
        last_cyc = cyc;
        nrsp++;
        if (nrsp == 4) begin
          sif.req0_valid = 1'b0;
          sif.req1_valid = 1'b0;
        end
      end
      if (sif.req0_ready) begin e.id = 1'b0; e.out = 16'h0002; e.szcv = 4'b0010; e.p = 1; sb.push_back(e); end
      if (sif.req1_ready) begin e.id = 1'b1; e.out = 16'hFFFF; e.szcv = 4'b1010; e.p = 2; sb.push_back(e); end
      @(negedge clk);
    end
    total++; if (nrsp != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", nrsp); end
    sif.req0_valid = 1'b0;
    sif.req1_valid = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [3:0]  v_op[11];
    logic [15:0] v_br[11];
    logic [4:0]  v_amt[11];
    logic [15:0] v_out[11];
    logic [3:0]  v_szcv[11];
    logic [19:0] r;
    exp_t e, got_e;
    bit   ok, to;
    int   lat, npass, dsum;
    logic gid;
    logic [15:0] gout;
    logic [3:0]  gszcv;
    v_op[0] = 4'b1000; v_br[0] = 16'h8001; v_amt[0] = 5'd1;  v_out[0] = 16'h0002; v_szcv[0] = 4'b0010;
    v_op[1] = 4'b1011; v_br[1] = 16'h8000; v_amt[1] = 5'd20; v_out[1] = 16'hFFFF; v_szcv[1] = 4'b1010;
    v_op[2] = 4'b1001; v_br[2] = 16'h1234; v_amt[2] = 5'd31; v_out[2] = 16'h091A; v_szcv[2] = 4'b0000;
    v_op[3] = 4'b1010; v_br[3] = 16'h00F0; v_amt[3] = 5'd0;  v_out[3] = 16'h00F0; v_szcv[3] = 4'b0000;
    v_op[4] = 4'b0011; v_br[4] = 16'hABCD; v_amt[4] = 5'd9;  v_out[4] = 16'h0000; v_szcv[4] = 4'b0100;
    for (int i = 5; i < 11; i++) begin
      v_op[i]  = 4'b1000 | 4'($urandom_range(0, 3));
      v_br[i]  = 16'($urandom);
      v_amt[i] = (i == 5) ? 5'd16 : 5'($urandom_range(0, 31));
      r = ref_result(v_op[i], v_br[i], v_amt[i]);
      v_out[i]  = r[19:4];
      v_szcv[i] = r[3:0];
    end
    sif.rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      e.id = 1'(i % 2); e.out = v_out[i]; e.szcv = v_szcv[i]; e.p = exp_passes(v_op[i], v_amt[i]);
      send(e.id, v_op[i], v_br[i], v_amt[i], e, ok);
      total++; if (!ok) begin bad++; $display("FAIL vec%0d_grant got=timeout want=ready", i); continue; end
      wait_rsp(lat, npass, dsum, gid, gout, gszcv, to);
      total++; if (to) begin bad++; $display("FAIL vec%0d_rsp got=timeout want=rsp_valid", i); sb.delete(); continue; end
      got_e = sb.pop_front();
      total++; if (gout !== got_e.out) begin bad++; $display("FAIL vec%0d_out got=%h want=%h", i, gout, got_e.out); end
      total++; if (gszcv !== got_e.szcv) begin bad++; $display("FAIL vec%0d_szcv got=%b want=%b", i, gszcv, got_e.szcv); end
      total++; if (gid !== got_e.id) begin bad++; $display("FAIL vec%0d_id got=%b want=%b", i, gid, got_e.id); end
      total++; if (lat != got_e.p + 1) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, got_e.p + 1); end
      total++; if (npass != got_e.p) begin bad++; $display("FAIL vec%0d_passes got=%0d want=%0d", i, npass, got_e.p); end
      if (v_op[i][3:2] == 2'b10) begin
        total++; if (dsum != int'(v_amt[i])) begin bad++; $display("FAIL vec%0d_dsum got=%0d want=%0d", i, dsum, v_amt[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    bit   seen;
    e.id = 1'b0; e.out = 16'h091A; e.szcv = 4'b0000; e.p = 3;
    sif.rsp_ready = 1'b0;
    send(1'b0, 4'b1001, 16'h1234, 5'd31, e, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_grant got=timeout want=ready"); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sif.rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_rsp got=timeout want=rsp_valid"); end
    if (sb.size() > 0) e = sb.pop_front();
    drive_req(1'b0, 1'b1, 4'b1000, 16'h0001, 5'd1);
    drive_req(1'b1, 1'b1, 4'b1000, 16'h0001, 5'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (sif.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, sif.rsp_valid); end
      total++; if (sif.rsp_out !== e.out) begin bad++; $display("FAIL bp_out[%0d] got=%h want=%h", i, sif.rsp_out, e.out); end
      total++; if (sif.rsp_szcv !== e.szcv) begin bad++; $display("FAIL bp_szcv[%0d] got=%b want=%b", i, sif.rsp_szcv, e.szcv); end
      total++; if ({sif.req0_ready, sif.req1_ready} !== 2'b00) begin bad++;
        $display("FAIL bp_ready[%0d] got=%b%b want=00", i, sif.req0_ready, sif.req1_ready); end
      total++; if (sif.busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%b want=1", i, sif.busy); end
      @(negedge clk);
    end
    sif.rsp_ready = 1'b1;
    #1;
    total++; if ({sif.req0_ready, sif.req1_ready} !== 2'b00) begin bad++;
      $display("FAIL bp_release_ready got=%b%b want=00", sif.req0_ready, sif.req1_ready); end
    sif.req0_valid = 1'b0;
    sif.req1_valid = 1'b0;
    @(negedge clk);
    total++; if ({sif.rsp_valid, sif.busy} !== 2'b00) begin bad++;
      $display("FAIL bp_done got=%b%b want=00", sif.rsp_valid, sif.busy); end
  endtask

  // reset in the second pass of a 15+5 request; afterwards req0 wins first
  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    int   nrsp;
    e.id = 1'b1; e.out = 16'hFFFF; e.szcv = 4'b1010; e.p = 2;
    sif.rsp_ready = 1'b1;
    send(1'b1, 4'b1011, 16'h8000, 5'd20, e, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_grant got=timeout want=ready"); end
    @(negedge clk);
    total++; if (sif.sh_d !== 4'd5) begin bad++; $display("FAIL rst_mid_pass2_d got=%0d want=5", sif.sh_d); end
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", sif.busy); end
    total++; if (sif.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_rsp_valid got=%b want=0", sif.rsp_valid); end
    drive_req(1'b0, 1'b1, 4'b1000, 16'h8001, 5'd1);
    #1;
    total++; if (sif.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready_forced got=%b want=0", sif.req0_ready); end
    rst_n = 1'b1;
    drive_req(1'b1, 1'b1, 4'b1011, 16'h8000, 5'd20);
    #1;
    total++; if ({sif.req0_ready, sif.req1_ready} !== 2'b10) begin bad++;
      $display("FAIL rst_mid_first_grant got=%b%b want=10", sif.req0_ready, sif.req1_ready); end
    nrsp = 0;
    for (int cyc = 0; cyc < 40 && nrsp < 2; cyc++) begin
      #1;
      if (sif.rsp_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++; if ({sif.rsp_id, sif.rsp_out, sif.rsp_szcv} !== {e.id, e.out, e.szcv}) begin bad++;
            $display("FAIL rst_mid_rsp[%0d] got=%b/%h/%b want=%b/%h/%b", nrsp,
                     sif.rsp_id, sif.rsp_out, sif.rsp_szcv, e.id, e.out, e.szcv); end
        end
        nrsp++;
        if (nrsp == 2) begin
          sif.req0_valid = 1'b0;
          sif.req1_valid = 1'b0;
        end
      end
      if (sif.req0_ready) begin e.id = 1'b0; e.out = 16'h0002; e.szcv = 4'b0010; e.p = 1; sb.push_back(e); end
      if (sif.req1_ready) begin e.id = 1'b1; e.out = 16'hFFFF; e.szcv = 4'b1010; e.p = 2; sb.push_back(e); end
      @(negedge clk);
    end
    total++; if (nrsp != 2) begin bad++; $display("FAIL rst_mid_count got=%0d want=2", nrsp); end
    sif.req0_valid = 1'b0;
    sif.req1_valid = 1'b0;
  endtask

  initial begin
    sif.req0_valid = 1'b0; sif.req0_br = 16'h0; sif.req0_amt = 5'd0; sif.req0_op = 4'h0;
    sif.req1_valid = 1'b0; sif.req1_br = 16'h0; sif.req1_amt = 5'd0; sif.req1_op = 4'h0;
    sif.rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
